// File: rtl/swap_ctrl.sv
// Memory-swap sequencer: reads A into temp, reads B, writes B's data to A and temp to B.
// Each memory access is bounded by a wait counter; an expired wait lands in ERR.
//
// state  | meaning
// IDLE   | waiting for Start; captures addresses on acceptance
// RD_A   | read word A into the memory buffer
// LD_T   | copy memory buffer into temp register
// RD_B   | read word B into the memory buffer
// WR_A   | write memory buffer (old B) to A
// WR_B   | write temp register (old A) to B
// DONE   | one-cycle completion pulse
// ERR    | memory ack timeout; Error set, back to IDLE
module swap_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr_A,
  input  logic [ADDR_W-1:0] Addr_B,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ack,
  output logic              Load_Buf,
  output logic              Load_Temp,
  output logic              Data_Sel
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_LD_T, S_RD_B, S_WR_A, S_WR_B, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_wait_cnt;
  logic              r_error;
  logic              w_in_mem;
  logic              w_timeout;
  logic              w_accept;

  assign w_in_mem  = (r_state == S_RD_A) || (r_state == S_RD_B) ||
                     (r_state == S_WR_A) || (r_state == S_WR_B);
  // An ack in the last allowed cycle takes priority over the timeout.
  assign w_timeout = w_in_mem && !Mem_Ack && (r_wait_cnt == LP_LAST_WAIT);
  assign w_accept  = (r_state == S_IDLE) && Start;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (Start) w_next = (Addr_A == Addr_B) ? S_DONE : S_RD_A;
      S_RD_A: if (Mem_Ack) w_next = S_LD_T; else if (w_timeout) w_next = S_ERR;
      S_LD_T: w_next = S_RD_B;
      S_RD_B: if (Mem_Ack) w_next = S_WR_A; else if (w_timeout) w_next = S_ERR;
      S_WR_A: if (Mem_Ack) w_next = S_WR_B; else if (w_timeout) w_next = S_ERR;
      S_WR_B: if (Mem_Ack) w_next = S_DONE; else if (w_timeout) w_next = S_ERR;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy      = (r_state != S_IDLE);
    Done      = 1'b0;
    Mem_Req   = 1'b0;
    Mem_We    = 1'b0;
    Load_Buf  = 1'b0;
    Load_Temp = 1'b0;
    Data_Sel  = 1'b0;
    unique case (r_state)
      S_RD_A, S_RD_B: begin
        Mem_Req  = 1'b1;
        Load_Buf = Mem_Ack;
      end
      S_WR_A: begin
        Mem_Req = 1'b1;
        Mem_We  = 1'b1;
      end
      S_WR_B: begin
        Mem_Req  = 1'b1;
        Mem_We   = 1'b1;
        Data_Sel = 1'b1;
      end
      S_LD_T:  Load_Temp = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Mem_Addr = r_mem_addr;
  assign Error    = r_error;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else if (w_accept) begin
      r_addr_a <= Addr_A;
      r_addr_b <= Addr_B;
    end
  end

  // Address register loads on entry to a memory state so it stays stable while
  // Mem_Req is high and keeps its last value outside memory states.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_mem_addr <= '0;
    end else if (w_next != r_state) begin
      unique case (w_next)
        S_RD_A:         r_mem_addr <= Addr_A;
        S_WR_A:         r_mem_addr <= r_addr_a;
        S_RD_B, S_WR_B: r_mem_addr <= r_addr_b;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                    r_wait_cnt <= '0;
    else if (w_next != r_state)    r_wait_cnt <= '0;
    else if (w_in_mem && !Mem_Ack) r_wait_cnt <= r_wait_cnt + 16'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 r_error <= 1'b0;
    else if (w_accept)          r_error <= 1'b0;
    else if (w_next == S_ERR)   r_error <= 1'b1;
  end

endmodule

// File: doc/swap_ctrl.md
# swap_ctrl

Sequencing controller for the memory-swap datapath. On a host request it exchanges the contents of two memory words. It drives the memory request interface, the memory-buffer load, the temp-register load (`Load_Temp`) and the write-data mux select. It sits between the host command port and the existing memory buffer, temp register and data mux, and owns every control strobe for them.

## Interface
- `ADDR_W`, default 8: memory address width.
- `TIMEOUT`, default 255: maximum cycles to wait for `Mem_Ack` in any memory state; legal range 1..65535.

- `Clk`  in  1: clock, all logic on the rising edge.
- `Rst_n`  in  1: reset, asynchronous, active-low.
- `Start`  in  1: host swap request, sampled in IDLE only.
- `Addr_A`  in  `ADDR_W`: first word address, captured with `Start`.
- `Addr_B`  in  `ADDR_W`: second word address, captured with `Start`.
- `Busy`  out  1: high in every state except IDLE.
- `Done`  out  1: one-cycle pulse on successful completion.
- `Error`  out  1: sticky timeout flag.
- `Mem_Req`  out  1: memory access request.
- `Mem_We`  out  1: 1 means write, 0 means read; valid while `Mem_Req` is high.
- `Mem_Addr`  out  `ADDR_W`: access address.
- `Mem_Ack`  in  1: memory completion, sampled on the rising edge while `Mem_Req` is high.
- `Load_Buf`  out  1: memory buffer captures read data this cycle.
- `Load_Temp`  out  1: temp register captures memory buffer output.
- `Data_Sel`  out  1: write-data mux; 0 selects the memory buffer, 1 selects `Temp_Reg`.

## Operation
- States: IDLE, RD_A, LD_T, RD_B, WR_A, WR_B, DONE, ERR.
- IDLE: when `Start`=1, latch `Addr_A`/`Addr_B` into internal registers, clear `Error`, then:
  - if the addresses are equal, go to DONE (no memory traffic);
  - otherwise go to RD_A.
- RD_A: `Mem_Req`=1, `Mem_We`=0, `Mem_Addr`=A. On `Mem_Ack`, `Load_Buf`=1 combinationally in the same cycle, then go to LD_T.
- LD_T: `Load_Temp`=1 for exactly one cycle, then go to RD_B.
- RD_B: read at B. On `Mem_Ack`, `Load_Buf`=1, then go to WR_A.
- WR_A: `Mem_Req`=1, `Mem_We`=1, `Mem_Addr`=A, `Data_Sel`=0. On `Mem_Ack`, go to WR_B.
- WR_B: write at B with `Data_Sel`=1. On `Mem_Ack`, go to DONE.
- DONE: `Done`=1 for one cycle, then go to IDLE.
- ERR: `Error` is set; all strobes are low; go to IDLE next cycle. `Error` stays high until the next accepted `Start`.
- Wait counter (16-bit):
  - cleared on entry to each memory state (RD_A, RD_B, WR_A, WR_B); increments each cycle `Mem_Ack` is low.
  - when it reaches `TIMEOUT` without an ack, go to ERR.
  - an ack in that same cycle wins over the timeout.
- `Start` while `Busy` is ignored (not queued). `Addr_A`/`Addr_B` changes after capture have no effect.
- `Mem_Ack` outside a memory state is ignored.
- Outside memory states: `Mem_Req`, `Mem_We`, `Load_Buf`, `Load_Temp` are 0; `Data_Sel` is 0; `Mem_Addr` holds its last driven value.

## Timing
- Reset (asynchronous, `Rst_n`=0):
  - state goes to IDLE; address registers and counter go to 0;
  - all outputs go to 0, including `Error`;
  - any in-flight memory access is abandoned immediately (`Mem_Req` drops asynchronously).
- Zero-wait memory (ack in the first request cycle): `Start` sampled at edge 0 gives RD_A in cycle 1 through DONE in cycle 6, so `Done` is high 6 cycles after acceptance. Each wait cycle adds 1.
- Equal-address request: `Done` is high 1 cycle after acceptance.
- `Mem_Req` stays continuously high from state entry through the ack cycle, with `Mem_Addr`/`Mem_We` stable.
- `Busy` falls in the cycle after DONE or ERR. A new `Start` may be accepted in that IDLE cycle.

## Test plan
- Zero-wait swap with A=0x10, B=0x20, mem[0x10]=0xAAAA, mem[0x20]=0x5555:
  - `Done` is high exactly 6 cycles after `Start`;
  - afterwards mem[0x10]=0x5555 and mem[0x20]=0xAAAA;
  - `Load_Temp` pulses once, in cycle 2.
- Memory with 3 wait cycles per access: `Done` at cycle 18. `Mem_Addr`/`Mem_We` are stable while `Mem_Req` is high. Swap result is correct.
- A=B=0x33: `Done` at cycle 1, `Mem_Req` never asserted, memory unchanged.
- `TIMEOUT`=4, ack withheld in RD_B:
  - ERR is entered after 4 wait cycles and `Error`=1;
  - `Busy` drops the cycle after;
  - mem[A] is unchanged;
  - the next `Start` clears `Error`.
- `Start` pulsed with new addresses during WR_A: ignored. Original swap completes and only one `Done` is seen.
- `Rst_n` asserted mid-WR_B:
  - all outputs go to 0 asynchronously;
  - after release, state is IDLE and a fresh swap completes in 6 cycles.
